// File: rtl/dma_rd_arb.sv
// Round-robin arbiter sharing the DDR DMA read channel between the icache fill
// engine and the waveform fetch engine, with a per-grant beat budget.
//
// state  | meaning
// IDLE   | no owner, request path idle
// GNT_IC | icache owns the DMA read channel
// GNT_WV | waveform owns the DMA read channel
module dma_rd_arb #(
  parameter int unsigned BURST_MAX   = 64,
  parameter int unsigned HOLD_CYCLES = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         ic_priority,
  input  logic [32:0]  ic_read_dma_addr,
  input  logic         ic_read_dma_valid,
  output logic         ic_read_dma_ack,
  output logic [127:0] ic_read_dma_data,
  input  logic [32:0]  wv_read_dma_addr,
  input  logic         wv_read_dma_valid,
  output logic         wv_read_dma_ack,
  output logic [127:0] wv_read_dma_data,
  output logic [32:0]  dma_read_addr,
  output logic         dma_read_valid,
  input  logic         dma_read_ack,
  input  logic [127:0] dma_read_data,
  output logic [1:0]   grant,
  output logic         err_spurious_ack
);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    GNT_IC = 2'b01,
    GNT_WV = 2'b10
  } state_e;

  localparam logic [9:0] BEAT_LIMIT = 10'(BURST_MAX);
  localparam logic [3:0] HOLD_LIMIT = 4'(HOLD_CYCLES);

  state_e     state_q, state_d;
  logic       last_wv_q, last_wv_d;
  logic [9:0] beat_cnt_q, beat_cnt_d;
  logic [3:0] idle_cnt_q, idle_cnt_d;
  logic       err_q, err_d;

  logic own_ic, own_wv, own_valid, other_valid, fwd_ack, idle_hit, yield;

  assign own_ic      = (state_q == GNT_IC);
  assign own_wv      = (state_q == GNT_WV);
  assign own_valid   = (own_ic & ic_read_dma_valid) | (own_wv & wv_read_dma_valid);
  assign other_valid = (own_ic & wv_read_dma_valid) | (own_wv & ic_read_dma_valid);
  assign fwd_ack     = dma_read_ack & own_valid;
  assign idle_hit    = ((idle_cnt_q + 4'd1) == HOLD_LIMIT);
  assign yield       = (beat_cnt_q == BEAT_LIMIT) | idle_hit | (own_wv & ic_priority);

  always_comb begin
    state_d    = state_q;
    last_wv_d  = last_wv_q;
    beat_cnt_d = beat_cnt_q;
    idle_cnt_d = idle_cnt_q;
    err_d      = err_q | (dma_read_ack & ~own_valid);
    case (state_q)
      GNT_IC, GNT_WV: begin
        if (own_valid) begin
          idle_cnt_d = 4'd0;
          if (fwd_ack && (beat_cnt_q != BEAT_LIMIT)) beat_cnt_d = beat_cnt_q + 10'd1;
        end else if (other_valid && yield) begin
          // Switching only while the owner's valid is low keeps an outstanding beat intact.
          state_d    = own_ic ? GNT_WV : GNT_IC;
          last_wv_d  = own_ic;
          beat_cnt_d = 10'd0;
          idle_cnt_d = 4'd0;
        end else if (idle_hit) begin
          state_d    = IDLE;
          beat_cnt_d = 10'd0;
          idle_cnt_d = 4'd0;
        end else begin
          idle_cnt_d = idle_cnt_q + 4'd1;
        end
      end
      default: begin
        beat_cnt_d = 10'd0;
        idle_cnt_d = 4'd0;
        if (ic_read_dma_valid && (!wv_read_dma_valid || ic_priority || last_wv_q)) begin
          state_d   = GNT_IC;
          last_wv_d = 1'b0;
        end else if (wv_read_dma_valid) begin
          state_d   = GNT_WV;
          last_wv_d = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      last_wv_q  <= 1'b1;
      beat_cnt_q <= 10'd0;
      idle_cnt_q <= 4'd0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      last_wv_q  <= last_wv_d;
      beat_cnt_q <= beat_cnt_d;
      idle_cnt_q <= idle_cnt_d;
      err_q      <= err_d;
    end
  end

  assign grant            = state_q;
  assign dma_read_valid   = own_valid;
  assign dma_read_addr    = own_ic ? ic_read_dma_addr : (own_wv ? wv_read_dma_addr : 33'd0);
  assign ic_read_dma_ack  = fwd_ack & own_ic;
  assign wv_read_dma_ack  = fwd_ack & own_wv;
  assign ic_read_dma_data = dma_read_data;
  assign wv_read_dma_data = dma_read_data;
  assign err_spurious_ack = err_q;

endmodule

// File: tb/tb_dma_rd_arb.sv
// Directed bench for dma_rd_arb: a per-cycle vector table plus hand-written
// traffic sequences for budget rotation, solo bursts and mid-beat reset.
module tb_dma_rd_arb;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         ic_priority;
  logic [32:0]  ic_read_dma_addr;
  logic         ic_read_dma_valid;
  logic         ic_read_dma_ack;
  logic [127:0] ic_read_dma_data;
  logic [32:0]  wv_read_dma_addr;
  logic         wv_read_dma_valid;
  logic         wv_read_dma_ack;
  logic [127:0] wv_read_dma_data;
  logic [32:0]  dma_read_addr;
  logic         dma_read_valid;
  logic         dma_read_ack;
  logic [127:0] dma_read_data;
  logic [1:0]   grant;
  logic         err_spurious_ack;

  int n_cmp = 0;
  int n_bad = 0;

  dma_rd_arb #(.BURST_MAX(4), .HOLD_CYCLES(2)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .ic_priority       (ic_priority),
    .ic_read_dma_addr  (ic_read_dma_addr),
    .ic_read_dma_valid (ic_read_dma_valid),
    .ic_read_dma_ack   (ic_read_dma_ack),
    .ic_read_dma_data  (ic_read_dma_data),
    .wv_read_dma_addr  (wv_read_dma_addr),
    .wv_read_dma_valid (wv_read_dma_valid),
    .wv_read_dma_ack   (wv_read_dma_ack),
    .wv_read_dma_data  (wv_read_dma_data),
    .dma_read_addr     (dma_read_addr),
    .dma_read_valid    (dma_read_valid),
    .dma_read_ack      (dma_read_ack),
    .dma_read_data     (dma_read_data),
    .grant             (grant),
    .err_spurious_ack  (err_spurious_ack)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        pri;
    logic        iv;
    logic [32:0] ia;
    logic        wv;
    logic [32:0] wa;
    logic        ack;
    logic [1:0]  e_gnt;
    logic        e_dv;
    logic [32:0] e_addr;
    logic        e_ia;
    logic        e_wa;
    logic        e_err;
  } vec_t;

  localparam logic [32:0] A0 = 33'h1_2345_0000, A1 = 33'h1_2345_0010, A2 = 33'h1_2345_0020;
  localparam logic [32:0] A3 = 33'h1_2345_0030, A4 = 33'h1_2345_0040, A5 = 33'h1_2345_0050;
  localparam logic [32:0] B0 = 33'h0_8000_1000, B1 = 33'h0_8000_1010, B2 = 33'h0_8000_1020;
  localparam logic [32:0] IC_BASE = 33'h1_0000_0000;
  localparam logic [32:0] WV_BASE = 33'h0_4000_0000;
  localparam int NVEC = 25;

  vec_t vecs [NVEC];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic pri, input logic iv, input logic [32:0] ia,
                              input logic wv, input logic [32:0] wa, input logic ack,
                              input logic [1:0] e_gnt, input logic e_dv, input logic [32:0] e_addr,
                              input logic e_ia, input logic e_wa, input logic e_err);
    vec_t v;
    v.pri = pri; v.iv = iv; v.ia = ia; v.wv = wv; v.wa = wa; v.ack = ack;
    v.e_gnt = e_gnt; v.e_dv = e_dv; v.e_addr = e_addr;
    v.e_ia = e_ia; v.e_wa = e_wa; v.e_err = e_err;
    return v;
  endfunction

  task automatic drive_idle();
    ic_priority = 1'b0;
    ic_read_dma_valid = 1'b0; ic_read_dma_addr = '0;
    wv_read_dma_valid = 1'b0; wv_read_dma_addr = '0;
    dma_read_ack = 1'b0; dma_read_data = '0;
  endtask

  // Both requesters re-raise valid one cycle after each ack; the DMA acks any
  // presented request in the same cycle. Ack k belongs to ic for blocks of 4.
  task automatic run_traffic(input bit with_wv, input int n_acks, input int max_cycles);
    int  acks = 0, ic_n = 0, wv_n = 0;
    bit  icv = 1'b1, wvv = with_wv;
    bit  exp_wv, ic_hit, wv_hit;
    logic [127:0] dat;
    for (int cyc = 0; cyc < max_cycles && acks < n_acks; cyc++) begin
      @(negedge clk);
      ic_priority       = 1'b0;
      ic_read_dma_valid = icv;
      ic_read_dma_addr  = IC_BASE + 33'(ic_n * 16);
      wv_read_dma_valid = wvv;
      wv_read_dma_addr  = WV_BASE + 33'(wv_n * 16);
      dma_read_ack      = 1'b0;
      dat               = {32'hDA7A_0000 + 32'(cyc), 96'h1234_5678_9ABC_DEF0_0F1E_2D3C};
      dma_read_data     = dat;
      #1;
      if (cyc == 0) begin
        chk("tr_first_grant", grant, 2'b00);
        chk("tr_first_valid", dma_read_valid, 1'b0);
      end else if (cyc == 1) begin
        chk("tr_latency_valid", dma_read_valid, 1'b1);
      end
      if (!with_wv && cyc > 0) chk("solo_grant", grant, 2'b01);
      exp_wv = with_wv && (((acks / 4) % 2) == 1);
      if (dma_read_valid) begin
        chk("tr_owner_grant", grant, exp_wv ? 2'b10 : 2'b01);
        chk("tr_addr", dma_read_addr,
            exp_wv ? (WV_BASE + 33'(wv_n * 16)) : (IC_BASE + 33'(ic_n * 16)));
      end
      dma_read_ack = dma_read_valid;
      #1;
      ic_hit = 1'b0; wv_hit = 1'b0;
      if (dma_read_ack) begin
        chk("tr_ic_ack", ic_read_dma_ack, !exp_wv);
        chk("tr_wv_ack", wv_read_dma_ack, exp_wv);
        chk("tr_data", exp_wv ? wv_read_dma_data : ic_read_dma_data, dat);
        acks++;
        if (exp_wv) begin wv_hit = 1'b1; wv_n++; end
        else begin ic_hit = 1'b1; ic_n++; end
      end else begin
        chk("tr_no_ack", {ic_read_dma_ack, wv_read_dma_ack}, 2'b00);
      end
      icv = !ic_hit;
      wvv = with_wv && !wv_hit;
    end
    chk("tr_ack_count", 32'(acks), 32'(n_acks));
    @(negedge clk);
    drive_idle();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vecs[0]  = mk(0, 0, '0, 0, '0, 0, 2'b00, 0, '0, 0, 0, 0);
    vecs[1]  = mk(0, 1, A0, 0, '0, 0, 2'b00, 0, '0, 0, 0, 0);
    vecs[2]  = mk(0, 1, A0, 0, '0, 1, 2'b01, 1, A0, 1, 0, 0);
    vecs[3]  = mk(0, 0, A1, 0, '0, 0, 2'b01, 0, A1, 0, 0, 0);
    vecs[4]  = mk(0, 1, A1, 0, '0, 1, 2'b01, 1, A1, 1, 0, 0);
    vecs[5]  = mk(0, 0, A2, 1, B0, 0, 2'b01, 0, A2, 0, 0, 0);
    vecs[6]  = mk(0, 1, A2, 1, B0, 1, 2'b01, 1, A2, 1, 0, 0);
    vecs[7]  = mk(0, 0, A3, 1, B0, 0, 2'b01, 0, A3, 0, 0, 0);
    vecs[8]  = mk(0, 1, A3, 1, B0, 1, 2'b01, 1, A3, 1, 0, 0);
    vecs[9]  = mk(0, 0, A4, 1, B0, 0, 2'b01, 0, A4, 0, 0, 0);
    vecs[10] = mk(0, 1, A4, 1, B0, 1, 2'b10, 1, B0, 0, 1, 0);
    vecs[11] = mk(1, 1, A4, 0, B1, 0, 2'b10, 0, B1, 0, 0, 0);
    vecs[12] = mk(0, 1, A4, 1, B1, 1, 2'b01, 1, A4, 1, 0, 0);
    vecs[13] = mk(0, 0, A5, 0, B1, 0, 2'b01, 0, A5, 0, 0, 0);
    vecs[14] = mk(0, 0, A5, 0, B1, 0, 2'b01, 0, A5, 0, 0, 0);
    vecs[15] = mk(0, 0, A5, 1, B1, 0, 2'b00, 0, '0, 0, 0, 0);
    vecs[16] = mk(0, 0, A5, 1, B1, 1, 2'b10, 1, B1, 0, 1, 0);
    vecs[17] = mk(0, 0, A5, 0, B2, 1, 2'b10, 0, B2, 0, 0, 0);
    vecs[18] = mk(0, 0, A5, 0, B2, 0, 2'b10, 0, B2, 0, 0, 1);
    vecs[19] = mk(0, 0, A5, 0, B2, 0, 2'b00, 0, '0, 0, 0, 1);
    vecs[20] = mk(0, 1, A5, 1, B2, 0, 2'b00, 0, '0, 0, 0, 1);
    vecs[21] = mk(0, 1, A5, 1, B2, 1, 2'b01, 1, A5, 1, 0, 1);
    vecs[22] = mk(0, 0, A5, 1, B2, 0, 2'b01, 0, A5, 0, 0, 1);
    vecs[23] = mk(0, 0, A5, 1, B2, 0, 2'b01, 0, A5, 0, 0, 1);
    vecs[24] = mk(0, 0, A5, 1, B2, 1, 2'b10, 1, B2, 0, 1, 1);

    rst_n = 1'b0;
    drive_idle();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_grant", grant, 2'b00);
    chk("rst_valid", dma_read_valid, 1'b0);
    chk("rst_err", err_spurious_ack, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < NVEC; i++) begin
      @(negedge clk);
      ic_priority       = vecs[i].pri;
      ic_read_dma_valid = vecs[i].iv;
      ic_read_dma_addr  = vecs[i].ia;
      wv_read_dma_valid = vecs[i].wv;
      wv_read_dma_addr  = vecs[i].wa;
      dma_read_ack      = vecs[i].ack;
      dma_read_data     = {4{32'hD00D_0000 + 32'(i)}};
      #1;
      chk($sformatf("v%0d_grant", i), grant, vecs[i].e_gnt);
      chk($sformatf("v%0d_valid", i), dma_read_valid, vecs[i].e_dv);
      chk($sformatf("v%0d_addr", i), dma_read_addr, vecs[i].e_addr);
      chk($sformatf("v%0d_ic_ack", i), ic_read_dma_ack, vecs[i].e_ia);
      chk($sformatf("v%0d_wv_ack", i), wv_read_dma_ack, vecs[i].e_wa);
      chk($sformatf("v%0d_err", i), err_spurious_ack, vecs[i].e_err);
      chk($sformatf("v%0d_ic_data", i), ic_read_dma_data, {4{32'hD00D_0000 + 32'(i)}});
      chk($sformatf("v%0d_wv_data", i), wv_read_dma_data, {4{32'hD00D_0000 + 32'(i)}});
    end

    // Waveform owns with a beat outstanding; reset lands between clock edges.
    @(negedge clk);
    ic_priority = 1'b0; ic_read_dma_valid = 1'b0;
    wv_read_dma_valid = 1'b1; wv_read_dma_addr = B2; dma_read_ack = 1'b0;
    #1;
    chk("midrst_pre_grant", grant, 2'b10);
    chk("midrst_pre_valid", dma_read_valid, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_grant", grant, 2'b00);
    chk("midrst_valid", dma_read_valid, 1'b0);
    chk("midrst_addr", dma_read_addr, 33'd0);
    chk("midrst_err", err_spurious_ack, 1'b0);
    @(negedge clk);
    drive_idle();
    #1;
    rst_n = 1'b1;

    run_traffic(1'b0, 8, 100);

    @(negedge clk);
    rst_n = 1'b0;
    drive_idle();
    @(negedge clk);
    rst_n = 1'b1;

    run_traffic(1'b1, 16, 200);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/dma_rd_arb.md
# dma_rd_arb

Arbiter that shares the single DDR DMA read channel between the instruction-cache fill engine (prefill/refill, 16-byte beats) and the waveform-sample fetch engine. It sits between both requesters and the DMA controller. Both sides use the same valid/ack beat handshake, with address held until ack and data valid with ack. Grants are round-robin with a bounded beat budget, so a 512-beat cache prefill cannot starve waveform playback, and vice versa.

## Interface
- BURST_MAX, 64: beats a grant may consume before yielding to a waiting requester (1..1023)
- HOLD_CYCLES, 2: consecutive owner-valid-low cycles before the grant is released (1..15)
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- ic_priority  in  1  1: icache preempts waveform at the next beat boundary, ignoring the budget
- ic_read_dma_addr  in  33  icache request byte address
- ic_read_dma_valid  in  1  icache request
- ic_read_dma_ack  out  1  icache beat accepted, data valid
- ic_read_dma_data  out  128  icache read data
- wv_read_dma_addr  in  33  waveform request byte address
- wv_read_dma_valid  in  1  waveform request
- wv_read_dma_ack  out  1  waveform beat accepted, data valid
- wv_read_dma_data  out  128  waveform read data
- dma_read_addr  out  33  address to DMA controller
- dma_read_valid  out  1  request to DMA controller
- dma_read_ack  in  1  DMA beat done (1-cycle pulse)
- dma_read_data  in  128  DMA read data, valid with dma_read_ack
- grant  out  2  01 icache, 10 waveform, 00 none (registered)
- err_spurious_ack  out  1  sticky: dma_read_ack seen while dma_read_valid low

## Operation
- States: IDLE, GNT_IC, GNT_WV. The grant is registered. The request and ack paths are combinational through the grant.
- dma_read_valid = owner valid AND owner granted. dma_read_addr = owner addr, or 0 in IDLE.
- Owner ack = dma_read_ack AND grant bit. Non-owner ack is 0. dma_read_data fans out to both data ports unmodified.
- IDLE: one valid wins. If both are valid: ic_priority=1 selects ic; otherwise the requester not granted last wins (last_grant resets to waveform, so ic wins the first tie).
- On grant entry: beat_cnt=0, idle_cnt=0. beat_cnt increments on each forwarded ack and saturates at BURST_MAX.
- idle_cnt counts consecutive cycles with owner valid low. It clears when owner valid is high.
- The grant changes only in a cycle where owner valid is low, so an outstanding request is never switched.
- In such a cycle, with the other requester valid, switch directly to the other requester (next state GNT_other) if any of these holds:
  - beat_cnt==BURST_MAX
  - idle_cnt+1==HOLD_CYCLES
  - the owner is waveform and ic_priority=1
- Otherwise, if idle_cnt+1==HOLD_CYCLES and the other requester is not valid, go to IDLE.
- Otherwise keep the grant. A single-cycle valid gap between beats (fill engine behaviour) keeps the grant when HOLD_CYCLES>=2.
- err_spurious_ack sets on dma_read_ack & !dma_read_valid. Such an ack is not forwarded. The flag clears only by reset.

## Timing
- Reset: grant=00, last_grant=waveform, beat_cnt=0, idle_cnt=0, err_spurious_ack=0. Therefore dma_read_valid=0, dma_read_addr=0, both acks=0.
- Reset mid-beat drops the request immediately. Requesters are reset by the same rst_n.
- Latency from requester valid rise (IDLE) to dma_read_valid: 1 cycle (grant registered).
- Owner already granted: dma_read_valid follows owner valid in the same cycle.
- dma_read_ack to requester ack: 0 cycles. Data passes through with no added latency.
- Switch penalty: the new owner's request reaches DMA the cycle after the switch decision. No dead cycle beyond the owner's valid-low cycle.
- Simultaneous ic/wv valid rise in IDLE: resolved in one cycle per the tie rule.
- A beat_cnt at BURST_MAX with no other requester does not release the grant.

## Test plan
- BURST_MAX=4, HOLD_CYCLES=2; ic alone issues 8 beats (valid low 1 cycle after each ack) -> grant stays 01 throughout; 8 ic acks; ic addresses appear unchanged on dma_read_addr.
- Both valid from reset, ic_priority=0 -> grant=01 for 4 beats, then 10 for 4 beats, alternating; no ack ever reaches the non-owner.
- Waveform owner at beat 1, ic_priority pulses 1 with ic valid -> switch to 01 at waveform's next valid-low cycle, not after 4 beats.
- Owner drops valid for 2 cycles, other idle -> grant returns to 00 on the second idle cycle; next request is granted 1 cycle after its valid.
- dma_read_ack pulsed while dma_read_valid=0 -> no requester ack; err_spurious_ack=1 and stays set.
- rst_n asserted mid-beat with valid high -> grant=00, dma_read_valid=0 asynchronously; after release, behaviour matches the first scenario.
